// File: rtl/seg_595_scan_param_if.sv
// Bus bundle between a host and the 74HC595 seven-segment scanner:
// display value/attributes in, serial chain control out.
interface seg_595_scan_param_if #(
  parameter int DIGITS   = 6,
  parameter int DATA_W   = 20,
  parameter int BRIGHT_W = 4
);
  logic [DATA_W-1:0]   data;
  logic [DIGITS-1:0]   point;
  logic                sign;
  logic                seg_en;
  logic [BRIGHT_W-1:0] bright;
  logic                ds;
  logic                shcp;
  logic                stcp;
  logic                oe;

  modport master (
    output data, point, sign, seg_en, bright,
    input  ds, shcp, stcp, oe
  );

  modport slave (
    input  data, point, sign, seg_en, bright,
    output ds, shcp, stcp, oe
  );
endinterface

// File: rtl/seg_595_scan_param.sv
// Multiplexed seven-segment driver for a 74HC595 chain: binary-to-BCD
// conversion, leading-zero blanking with minus sign, serial frame shifting
// per digit slot and PWM brightness on the active-low output enable.
module seg_595_scan_param #(
  parameter int DIGITS   = 6,
  parameter int DATA_W   = 20,
  parameter int SCAN_CNT = 50000,
  parameter int BRIGHT_W = 4
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  seg_595_scan_param_if.slave  bus
);
  localparam int F      = 8 + DIGITS;
  localparam int BCD_W  = 4 * DIGITS;
  localparam int WORK_W = BCD_W + DATA_W;
  localparam int CNT_W  = $clog2(SCAN_CNT);
  localparam int IDX_W  = CNT_W - 2;
  localparam int K_W    = $clog2(DIGITS);
  localparam int BIT_W  = $clog2(DATA_W + 1);
  localparam logic [63:0] MAX_VAL = 64'(10 ** DIGITS) - 64'd1;
  localparam logic [BRIGHT_W-1:0] PWM_MAX = BRIGHT_W'((1 << BRIGHT_W) - 2);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} conv_state_e;

  conv_state_e         state_q, state_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WORK_W-1:0]   work_q, work_d, adj;
  logic                ovf_q, ovf_d;
  logic [DIGITS-1:0]   cap_point_q, cap_point_d;
  logic                cap_sign_q, cap_sign_d, cap_en_q, cap_en_d;
  logic [BCD_W-1:0]    bcd_q, bcd_d;
  logic [DIGITS-1:0]   snap_point_q, snap_point_d;
  logic                snap_sign_q, snap_sign_d, snap_en_q, snap_en_d;

  logic [CNT_W-1:0]    cnt_scan_q, cnt_scan_d;
  logic [K_W-1:0]      k_q, k_d;
  logic [F-1:0]        frame_q, frame_d, new_frame;
  logic [IDX_W-1:0]    bit_idx;
  logic [BRIGHT_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic                ds_q, ds_d, shcp_q, shcp_d, stcp_q, stcp_d, oe_q, oe_d;

  logic [DIGITS-1:0]   blank, minus;
  logic                hi_zero;
  logic [3:0]          digit;
  logic                dig_blank, dig_minus, dig_point;
  logic [7:0]          seg;
  logic [DIGITS-1:0]   sel;

  function automatic logic [7:0] seg_of(input logic [3:0] v);
    case (v)
      4'd0:    seg_of = 8'hC0;
      4'd1:    seg_of = 8'hF9;
      4'd2:    seg_of = 8'hA4;
      4'd3:    seg_of = 8'hB0;
      4'd4:    seg_of = 8'h99;
      4'd5:    seg_of = 8'h92;
      4'd6:    seg_of = 8'h82;
      4'd7:    seg_of = 8'hF8;
      4'd8:    seg_of = 8'h80;
      4'd9:    seg_of = 8'h90;
      default: seg_of = 8'hFF;
    endcase
  endfunction

  // Converter FSM: capture, double-dabble, then commit BCD and attributes together.
  // Attributes are captured alongside data and only published at DONE so the
  // display never pairs a new point/sign with an old value.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    work_d       = work_q;
    ovf_d        = ovf_q;
    cap_point_d  = cap_point_q;
    cap_sign_d   = cap_sign_q;
    cap_en_d     = cap_en_q;
    bcd_d        = bcd_q;
    snap_point_d = snap_point_q;
    snap_sign_d  = snap_sign_q;
    snap_en_d    = snap_en_q;
    adj          = work_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (work_q[DATA_W + 4*i +: 4] >= 4'd5) begin
        adj[DATA_W + 4*i +: 4] = work_q[DATA_W + 4*i +: 4] + 4'd3;
      end
    end
    case (state_q)
      ST_IDLE: begin
        work_d              = '0;
        work_d[DATA_W-1:0]  = bus.data;
        ovf_d               = (64'(bus.data) > MAX_VAL);
        cap_point_d         = bus.point;
        cap_sign_d          = bus.sign;
        cap_en_d            = bus.seg_en;
        bit_cnt_d           = '0;
        state_d             = ST_SHIFT;
      end
      ST_SHIFT: begin
        work_d    = {adj[WORK_W-2:0], 1'b0};
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == BIT_W'(DATA_W - 1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        bcd_d        = ovf_q ? {DIGITS{4'h9}} : work_q[DATA_W +: BCD_W];
        snap_point_d = cap_point_q;
        snap_sign_d  = cap_sign_q;
        snap_en_d    = cap_en_q;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Blanking map: a digit is dark when it and everything above it is zero with no point.
  always_comb begin
    blank   = '0;
    minus   = '0;
    hi_zero = 1'b1;
    for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
      hi_zero  = hi_zero && (bcd_q[4*i +: 4] == 4'd0) && !snap_point_q[i];
      blank[i] = hi_zero;
    end
    for (int unsigned i = 1; i < DIGITS; i++) begin
      minus[i] = snap_sign_q && blank[i] && !blank[i-1];
    end
  end

  // Frame for the digit that the next slot will show.
  always_comb begin
    digit     = '0;
    dig_blank = 1'b0;
    dig_minus = 1'b0;
    dig_point = 1'b0;
    sel       = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (k_d == K_W'(i)) begin
        digit     = bcd_q[4*i +: 4];
        dig_blank = blank[i];
        dig_minus = minus[i];
        dig_point = snap_point_q[i];
        sel[i]    = 1'b1;
      end
    end
    if (dig_blank) begin
      seg = dig_minus ? 8'hBF : 8'hFF;
    end else begin
      seg = seg_of(digit) & (dig_point ? 8'h7F : 8'hFF);
    end
    new_frame = snap_en_q ? {seg, sel} : {8'hFF, {DIGITS{1'b0}}};
  end

  // Slot timing: outputs are registered from next-cycle counter values so they
  // line up with cnt_scan; bit i occupies slot cycles 4i..4i+3.
  always_comb begin
    cnt_scan_d = (cnt_scan_q == CNT_W'(SCAN_CNT - 1)) ? '0 : cnt_scan_q + 1'b1;
    k_d        = k_q;
    if (cnt_scan_q == CNT_W'(SCAN_CNT - 1)) begin
      k_d = (k_q == K_W'(DIGITS - 1)) ? '0 : k_q + 1'b1;
    end
    frame_d = (cnt_scan_d == '0) ? new_frame : frame_q;
    bit_idx = cnt_scan_d[CNT_W-1:2];
    ds_d    = 1'b0;
    shcp_d  = 1'b0;
    if (cnt_scan_d < CNT_W'(4 * F)) begin
      for (int unsigned i = 0; i < F; i++) begin
        if (bit_idx == IDX_W'(i)) begin
          ds_d = frame_d[i];
        end
      end
      shcp_d = cnt_scan_d[1];
    end
    stcp_d    = (cnt_scan_d == CNT_W'(4 * F));
    pwm_cnt_d = (pwm_cnt_q == PWM_MAX) ? '0 : pwm_cnt_q + 1'b1;
    oe_d      = !(pwm_cnt_d < bus.bright);
  end

  // Converter and snapshot registers.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      work_q       <= '0;
      ovf_q        <= 1'b0;
      cap_point_q  <= '0;
      cap_sign_q   <= 1'b0;
      cap_en_q     <= 1'b0;
      bcd_q        <= '0;
      snap_point_q <= '0;
      snap_sign_q  <= 1'b0;
      snap_en_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      work_q       <= work_d;
      ovf_q        <= ovf_d;
      cap_point_q  <= cap_point_d;
      cap_sign_q   <= cap_sign_d;
      cap_en_q     <= cap_en_d;
      bcd_q        <= bcd_d;
      snap_point_q <= snap_point_d;
      snap_sign_q  <= snap_sign_d;
      snap_en_q    <= snap_en_d;
    end
  end

  // Scan, frame, PWM and output registers.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt_scan_q <= '0;
      k_q        <= '0;
      frame_q    <= {8'hFF, {DIGITS{1'b0}}};
      pwm_cnt_q  <= '0;
      ds_q       <= 1'b0;
      shcp_q     <= 1'b0;
      stcp_q     <= 1'b0;
      oe_q       <= 1'b1;
    end else begin
      cnt_scan_q <= cnt_scan_d;
      k_q        <= k_d;
      frame_q    <= frame_d;
      pwm_cnt_q  <= pwm_cnt_d;
      ds_q       <= ds_d;
      shcp_q     <= shcp_d;
      stcp_q     <= stcp_d;
      oe_q       <= oe_d;
    end
  end

  assign bus.ds   = ds_q;
  assign bus.shcp = shcp_q;
  assign bus.stcp = stcp_q;
  assign bus.oe   = oe_q;
endmodule

// File: tb/tb_seg_595_scan_param.sv
// Bench for seg_595_scan_param: a behavioural 74HC595 receiver rebuilds each
// latched frame, which is compared to digits computed arithmetically from the
// applied value; also covers reset behaviour, slot timing and PWM duty.
module tb_seg_595_scan_param;
  localparam int DIGITS   = 6;
  localparam int DATA_W   = 20;
  localparam int SCAN_CNT = 100;
  localparam int BRIGHT_W = 4;
  localparam int F        = 8 + DIGITS;
  localparam logic [7:0] SEG_LUT [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                          8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg_595_scan_param_if #(.DIGITS(DIGITS), .DATA_W(DATA_W), .BRIGHT_W(BRIGHT_W)) bus ();

  seg_595_scan_param #(
    .DIGITS(DIGITS), .DATA_W(DATA_W), .SCAN_CNT(SCAN_CNT), .BRIGHT_W(BRIGHT_W)
  ) dut (
    .sys_clk(clk),
    .sys_rst(rst),
    .bus(bus)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: digits by decimal arithmetic; everything above the most
  // significant shown digit is dark, minus takes the first dark position.
  function automatic logic [F-1:0] model_frame(input int unsigned val, input logic [DIGITS-1:0] pt,
                                               input logic sg, input logic en, input int unsigned k);
    int unsigned d [DIGITS];
    int unsigned v, top, lim;
    logic [7:0] sg_code;
    logic [DIGITS-1:0] sl;
    if (!en) return {8'hFF, {DIGITS{1'b0}}};
    lim = 1;
    repeat (DIGITS) lim = lim * 10;
    v   = val;
    top = 0;
    for (int i = 0; i < DIGITS; i++) begin
      d[i] = (val > lim - 1) ? 9 : v % 10;
      v    = v / 10;
      if (d[i] != 0 || pt[i]) top = i;
    end
    if (k <= top) sg_code = SEG_LUT[d[k]] & (pt[k] ? 8'h7F : 8'hFF);
    else if (sg && k == top + 1) sg_code = 8'hBF;
    else sg_code = 8'hFF;
    sl = '0;
    sl[k] = 1'b1;
    return {sg_code, sl};
  endfunction

  // 74HC595 chain receiver
  logic [F-1:0] sr = '0;
  logic [F-1:0] latched [$];
  logic shcp_prev = 1'b0;
  int unsigned shcp_edges = 0;
  int unsigned stcp_rst_cnt = 0;
  longint cyc = 0;
  longint last_stcp = 0;
  bit have_last = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst) begin
      shcp_edges = 0;
      have_last  = 1'b0;
      shcp_prev  = 1'b0;
      if (bus.stcp) stcp_rst_cnt++;
    end else begin
      if (bus.shcp && !shcp_prev) begin
        sr = {bus.ds, sr[F-1:1]};
        shcp_edges++;
      end
      shcp_prev = bus.shcp;
      if (bus.stcp) begin
        latched.push_back(sr);
        check_eq("shcp_per_frame", 64'(shcp_edges), 64'(F));
        if (have_last) check_eq("stcp_period", 64'(cyc - last_stcp), 64'(SCAN_CNT));
        have_last  = 1'b1;
        last_stcp  = cyc;
        shcp_edges = 0;
      end
    end
  end

  int unsigned frame_idx = 0;

  task automatic get_frame(output logic [F-1:0] fr, output int unsigned k);
    int unsigned n = 0;
    while (latched.size() == 0 && n < SCAN_CNT + 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("frame_avail", 64'(latched.size() != 0), 64'd1);
    fr = (latched.size() != 0) ? latched.pop_front() : '0;
    k  = frame_idx % DIGITS;
    frame_idx++;
  endtask

  task automatic wait_stcp(output int unsigned n);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!bus.stcp && n < 2 * SCAN_CNT);
  endtask

  task automatic apply_and_check(input int unsigned d, input logic [DIGITS-1:0] pt,
                                 input logic sg, input logic en);
    logic [F-1:0] fr;
    int unsigned k;
    @(posedge clk);
    #1;
    frame_idx += latched.size();
    latched.delete();
    bus.data   = DATA_W'(d);
    bus.point  = pt;
    bus.sign   = sg;
    bus.seg_en = en;
    repeat (3) get_frame(fr, k);
    for (int i = 0; i < DIGITS; i++) begin
      get_frame(fr, k);
      check_eq($sformatf("frame d=%0d k=%0d", d, k), 64'(fr), 64'(model_frame(d, pt, sg, en, k)));
    end
  endtask

  task automatic pwm_check(input logic [BRIGHT_W-1:0] b);
    int unsigned lows = 0;
    bus.bright = b;
    repeat (4) @(posedge clk);
    repeat (60) begin
      @(negedge clk);
      if (!bus.oe) lows++;
    end
    check_eq($sformatf("oe_low b=%0d", b), 64'(lows), 64'(4 * b));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [F-1:0] fr;
    int unsigned k, n;
    bus.data = '0; bus.point = '0; bus.sign = 1'b0; bus.seg_en = 1'b0; bus.bright = 4'd15;
    repeat (3) @(negedge clk);
    check_eq("rst_ds", 64'(bus.ds), 64'd0);
    check_eq("rst_shcp", 64'(bus.shcp), 64'd0);
    check_eq("rst_stcp", 64'(bus.stcp), 64'd0);
    check_eq("rst_oe", 64'(bus.oe), 64'd1);
    bus.data = 20'd123456; bus.seg_en = 1'b1;
    rst = 1'b0;
    wait_stcp(n);
    check_eq("first_stcp_cycle", 64'(n), 64'(4 * F));
    get_frame(fr, k);
    check_eq("first_frame", 64'(fr), 64'({8'hFF, {DIGITS{1'b0}}}));

    apply_and_check(123456, 6'b000000, 1'b0, 1'b1);
    apply_and_check(5, 6'b000010, 1'b1, 1'b1);
    apply_and_check(1048575, 6'b000000, 1'b1, 1'b1);
    apply_and_check(123456, 6'b000000, 1'b0, 1'b0);
    apply_and_check(0, 6'b000000, 1'b1, 1'b1);
    for (int v = 0; v < 8; v++) begin
      apply_and_check($urandom_range(0, (1 << DATA_W) - 1) >> $urandom_range(0, 19),
                      ($urandom_range(0, 3) == 0) ? DIGITS'($urandom) : '0,
                      1'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0));
    end

    pwm_check(4'd0);
    pwm_check(4'd15);
    pwm_check(4'd5);
    pwm_check(4'($urandom_range(1, 14)));

    // Reset in slot cycle 20 of a frame
    wait_stcp(n);
    check_eq("sync_stcp", 64'(bus.stcp), 64'd1);
    repeat (SCAN_CNT - 4 * F + 20) @(posedge clk);
    #1;
    latched.delete();
    frame_idx = 0;
    stcp_rst_cnt = 0;
    rst = 1'b1;
    #1;
    check_eq("mid_rst_ds", 64'(bus.ds), 64'd0);
    check_eq("mid_rst_shcp", 64'(bus.shcp), 64'd0);
    check_eq("mid_rst_stcp", 64'(bus.stcp), 64'd0);
    check_eq("mid_rst_oe", 64'(bus.oe), 64'd1);
    repeat (60) @(negedge clk);
    check_eq("stcp_during_rst", 64'(stcp_rst_cnt), 64'd0);
    check_eq("rst_queue_empty", 64'(latched.size()), 64'd0);
    rst = 1'b0;
    wait_stcp(n);
    check_eq("post_rst_stcp_cycle", 64'(n), 64'(4 * F));
    get_frame(fr, k);
    check_eq("post_rst_frame", 64'(fr), 64'({8'hFF, {DIGITS{1'b0}}}));
    get_frame(fr, k);
    check_eq("post_rst_digit1", 64'(fr),
             64'(model_frame(bus.data, bus.point, bus.sign, bus.seg_en, k)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
